// File: rtl/pio_gen_pkg.sv
// pio_gen_pkg: register addresses, edge modes and ID constants for the GPIO peripheral
package pio_gen_pkg;
  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_DIR      = 3'd2;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd3;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd6;
  localparam logic [2:0] ADDR_ID       = 3'd7;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  localparam logic [15:0] ID_MAGIC = 16'h5049;
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/pio_gen_if.sv
// pio_gen_if: Avalon-MM slave bus bundle between the CPU data master and the GPIO peripheral
interface pio_gen_if;
  logic [2:0]  avs_gpio_address;
  logic [31:0] avs_gpio_writedata;
  logic [3:0]  avs_gpio_byteenable;
  logic        avs_gpio_write;
  logic        avs_gpio_read;
  logic [31:0] avs_gpio_readdata;
  logic        avs_gpio_waitrequest;
  modport master (
    output avs_gpio_address, avs_gpio_writedata, avs_gpio_byteenable, avs_gpio_write, avs_gpio_read,
    input  avs_gpio_readdata, avs_gpio_waitrequest
  );
  modport slave (
    input  avs_gpio_address, avs_gpio_writedata, avs_gpio_byteenable, avs_gpio_write, avs_gpio_read,
    output avs_gpio_readdata, avs_gpio_waitrequest
  );
endinterface

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: pin synchroniser chain with warm-up gated edge detection
module pio_sync_edge
  import pio_gen_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_BOTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] edge_pulse
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] prev_q, rise, fall;
  logic [CW-1:0] warm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= '0;
      warm_q  <= CW'(SYNC_STAGES + 1);
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pins};
      prev_q  <= sync_q;
      warm_q  <= warm_q - CW'(warm_q != '0);
    end
  end
  assign sync_q = chain_q[SYNC_STAGES-1];
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;
  assign edge_pulse = (warm_q != '0) ? '0 :
                      (EDGE_TYPE == EDGE_RISE) ? rise :
                      (EDGE_TYPE == EDGE_FALL) ? fall : (rise | fall);
endmodule

// File: rtl/pio_gen.sv
// pio_gen: parametrised GPIO with set/clear, synchronised inputs, edge capture and masked irq
module pio_gen
  import pio_gen_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_BOTH
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset,
  pio_gen_if.slave         avs,
  output logic             ins_irq_irq,
  inout  wire  [WIDTH-1:0] coe_P
);
  localparam logic [31:0] WMASK = 32'((64'd1 << WIDTH) - 64'd1);
  logic [31:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d, rdata_q, rdata_d;
  logic [31:0] lanes, wd;
  logic [2:0] a;
  logic wr, irq_q;
  logic [WIDTH-1:0] sync_q, edge_pulse;
  always_comb begin
    a     = avs.avs_gpio_address;
    wr    = avs.avs_gpio_write;
    lanes = lane_mask(avs.avs_gpio_byteenable);
    wd    = avs.avs_gpio_writedata & lanes;
    out_d = WMASK & (!wr ? out_q :
                     a == ADDR_DATA_OUT ? (out_q & ~lanes) | wd :
                     a == ADDR_OUT_SET  ? out_q | wd :
                     a == ADDR_OUT_CLR  ? out_q & ~wd : out_q);
    dir_d  = WMASK & ((wr && a == ADDR_DIR) ? (dir_q & ~lanes) | wd : dir_q);
    mask_d = WMASK & ((wr && a == ADDR_IRQ_MASK) ? (mask_q & ~lanes) | wd : mask_q);
    cap_d  = WMASK & ((cap_q & ~((wr && a == ADDR_EDGE_CAP) ? wd : 32'd0)) | 32'(edge_pulse));
    rdata_d = !avs.avs_gpio_read  ? 32'd0 :
              a == ADDR_DATA_IN   ? 32'(sync_q) :
              a == ADDR_DATA_OUT  ? out_q :
              a == ADDR_DIR       ? dir_q :
              a == ADDR_IRQ_MASK  ? mask_q :
              a == ADDR_EDGE_CAP  ? cap_q :
              a == ADDR_ID        ? {ID_MAGIC, 8'(SYNC_STAGES), 8'(WIDTH)} : 32'd0;
  end
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      out_q   <= '0;
      dir_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      irq_q   <= |(cap_q & mask_q);
    end
  end
  assign avs.avs_gpio_readdata    = rdata_q;
  assign avs.avs_gpio_waitrequest = 1'b0;
  assign ins_irq_irq = irq_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign coe_P[i] = dir_q[i] ? out_q[i] : 1'bz;
  end
  pio_sync_edge #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE(EDGE_TYPE)
  ) u_sync (
    .clk(csi_MCLK_clk),
    .rst(rsi_MRST_reset),
    .pins(coe_P),
    .sync_q(sync_q),
    .edge_pulse(edge_pulse)
  );
endmodule

// File: tb/tb_pio_gen.sv
// tb_pio_gen: directed self-checking bench for pio_gen (rising-edge and both-edge instances)
module tb_pio_gen;
  import pio_gen_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pio_gen_if bus0 ();
  pio_gen_if bus2 ();
  logic [2:0] addr;
  logic [31:0] wdata, r0, r2;
  logic [3:0] be;
  logic wr, rd, irq0, irq2;
  logic [15:0] en0, val0, en2, val2;
  tri [15:0] pins0, pins2;
  int checks = 0;
  int failures = 0;
  assign bus0.avs_gpio_address = addr;
  assign bus0.avs_gpio_writedata = wdata;
  assign bus0.avs_gpio_byteenable = be;
  assign bus0.avs_gpio_write = wr;
  assign bus0.avs_gpio_read = rd;
  assign bus2.avs_gpio_address = addr;
  assign bus2.avs_gpio_writedata = wdata;
  assign bus2.avs_gpio_byteenable = be;
  assign bus2.avs_gpio_write = wr;
  assign bus2.avs_gpio_read = rd;
  for (genvar i = 0; i < 16; i++) begin : g_drv
    assign pins0[i] = en0[i] ? val0[i] : 1'bz;
    assign pins2[i] = en2[i] ? val2[i] : 1'bz;
  end
  pio_gen #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE)) u0 (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .avs(bus0), .ins_irq_irq(irq0), .coe_P(pins0)
  );
  pio_gen #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_BOTH)) u2 (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .avs(bus2), .ins_irq_irq(irq2), .coe_P(pins2)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a;
    wdata = d;
    be = b;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic bus_read(input logic [2:0] a, output logic [31:0] o0, output logic [31:0] o2);
    addr = a;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    o0 = bus0.avs_gpio_readdata;
    o2 = bus2.avs_gpio_readdata;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    addr = '0; wdata = '0; be = '0; wr = 1'b0; rd = 1'b0;
    en0 = 16'hFFFF; val0 = 16'h0000;
    en2 = 16'hFFFF; val2 = 16'h0010;
    tick(3);
    check("rst_rdata0", bus0.avs_gpio_readdata, 32'd0);
    check("rst_irq0", 32'(irq0), 32'd0);
    check("rst_irq2", 32'(irq2), 32'd0);
    check("waitrequest", 32'(bus0.avs_gpio_waitrequest), 32'd0);
    rst = 1'b0;
    bus_read(ADDR_ID, r0, r2);
    check("id", r0, 32'h5049_0210);
    for (int a = 0; a < 7; a++) begin
      bus_read(3'(a), r0, r2);
      check($sformatf("reset_reg_%0d", a), r0, 32'd0);
    end
    bus_read(ADDR_DATA_IN, r0, r2);
    check("held_pin4_din", r2, 32'h0000_0010);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("warmup_no_cap", r2, 32'd0);
    check("idle_rdata", bus0.avs_gpio_readdata, 32'd0);
    val0 = 16'hC35A;
    tick(2);
    bus_read(ADDR_DATA_IN, r0, r2);
    check("undriven_din", r0, 32'h0000_C35A);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("rise_cap_all", r0, 32'h0000_C35A);
    val0 = 16'h0000;
    tick(4);
    bus_write(ADDR_EDGE_CAP, 32'h0000_FFFF, 4'hF);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("w1c_all", r0, 32'd0);
    en0 = 16'hFF00;
    en2 = 16'hFF00;
    bus_write(ADDR_DIR, 32'h0000_00FF, 4'hF);
    bus_write(ADDR_DATA_OUT, 32'h0000_00A5, 4'hF);
    check("pins_a5", 32'(pins0), 32'h0000_00A5);
    bus_write(ADDR_OUT_SET, 32'h0000_0002, 4'hF);
    check("pins_a7", 32'(pins0), 32'h0000_00A7);
    bus_write(ADDR_OUT_CLR, 32'h0000_0001, 4'hF);
    check("pins_a6", 32'(pins0), 32'h0000_00A6);
    tick(2);
    bus_read(ADDR_DATA_IN, r0, r2);
    check("din_a6", r0, 32'h0000_00A6);
    bus_read(ADDR_DIR, r0, r2);
    check("dir_ff", r0, 32'h0000_00FF);
    bus_write(ADDR_DATA_OUT, 32'd0, 4'hF);
    bus_write(ADDR_DATA_OUT, 32'h0000_FFFF, 4'b0010);
    bus_read(ADDR_DATA_OUT, r0, r2);
    check("be_lane1", r0, 32'h0000_FF00);
    bus_write(ADDR_OUT_SET, 32'hFFFF_FFFF, 4'b0001);
    bus_read(ADDR_DATA_OUT, r0, r2);
    check("set_be", r0, 32'h0000_FFFF);
    bus_write(ADDR_DATA_OUT, 32'hFFFF_FFFF, 4'hF);
    bus_read(ADDR_DATA_OUT, r0, r2);
    check("width_trunc", r0, 32'h0000_FFFF);
    bus_write(ADDR_OUT_CLR, 32'hFFFF_FFFF, 4'b1110);
    bus_read(ADDR_DATA_OUT, r0, r2);
    check("clr_be", r0, 32'h0000_00FF);
    bus_read(ADDR_OUT_SET, r0, r2);
    check("wo_reads0", r0, 32'd0);
    bus_write(ADDR_OUT_CLR, 32'h0000_00FF, 4'hF);
    tick(4);
    bus_write(ADDR_EDGE_CAP, 32'h0000_FFFF, 4'hF);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("w1c_all2", r0, 32'd0);
    bus_write(ADDR_IRQ_MASK, 32'h0000_0200, 4'hF);
    val0 = 16'h0200;
    tick(2);
    check("irq_pre", 32'(irq0), 32'd0);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("cap_2clk", r0, 32'd0);
    check("irq_not_yet", 32'(irq0), 32'd0);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("cap_3clk", r0, 32'h0000_0200);
    check("irq_rise", 32'(irq0), 32'd1);
    val0 = 16'h0000;
    tick(4);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("fall_ignored", r0, 32'h0000_0200);
    check("irq_held", 32'(irq0), 32'd1);
    bus_write(ADDR_EDGE_CAP, 32'h0000_0200, 4'hF);
    check("irq_lag", 32'(irq0), 32'd1);
    tick(1);
    check("irq_drop", 32'(irq0), 32'd0);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("w1c_bit9", r0, 32'd0);
    bus_write(ADDR_IRQ_MASK, 32'h0000_0008, 4'hF);
    bus_write(ADDR_OUT_SET, 32'h0000_0008, 4'hF);
    tick(4);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("out_pin_cap", r0, 32'h0000_0008);
    check("irq_bit3", 32'(irq0), 32'd1);
    bus_write(ADDR_OUT_CLR, 32'h0000_0008, 4'hF);
    tick(3);
    bus_write(ADDR_OUT_SET, 32'h0000_0008, 4'hF);
    tick(2);
    bus_write(ADDR_EDGE_CAP, 32'h0000_0008, 4'hF);
    check("irq_hold", 32'(irq0), 32'd1);
    tick(1);
    check("irq_hold2", 32'(irq0), 32'd1);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("set_wins", r0, 32'h0000_0008);
    bus_write(ADDR_IRQ_MASK, 32'd0, 4'hF);
    check("mask_lag", 32'(irq0), 32'd1);
    tick(1);
    check("mask_off", 32'(irq0), 32'd0);
    bus_write(ADDR_IRQ_MASK, 32'h0000_0008, 4'hF);
    tick(1);
    check("mask_on", 32'(irq0), 32'd1);
    addr = ADDR_DATA_OUT;
    wdata = 32'h0000_1234;
    be = 4'hF;
    wr = 1'b1;
    rd = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    check("rw_pre", bus0.avs_gpio_readdata, 32'h0000_0008);
    bus_read(ADDR_DATA_OUT, r0, r2);
    check("rw_post", r0, 32'h0000_1234);
    check("irq_pending", 32'(irq0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_irq_drop", 32'(irq0), 32'd0);
    en0 = 16'hFFFF;
    val0 = 16'h0000;
    en2 = 16'hFFFF;
    val2 = 16'h0010;
    tick(2);
    rst = 1'b0;
    bus_read(ADDR_DIR, r0, r2);
    check("rst_dir0", r0, 32'd0);
    check("rst_dir2", r2, 32'd0);
    tick(2);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("warmup2_no_cap", r2, 32'd0);
    check("rst_cap0", r0, 32'd0);
    bus_read(ADDR_DATA_IN, r0, r2);
    check("pin4_high", r2, 32'h0000_0010);
    val2 = 16'h0000;
    tick(3);
    bus_read(ADDR_EDGE_CAP, r0, r2);
    check("fall_cap_both", r2, 32'h0000_0010);
    check("irq2_masked", 32'(irq2), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
